// File: rtl/gray_seq_checker.sv
// rtl/gray_seq_checker.sv - Gray-code sequence monitor: converts to binary, checks +1 steps, tracks lock
module gray_seq_checker #(
    parameter int DATA_WIDTH    = 4,
    parameter int ALLOW_HOLD    = 1,
    parameter int RELOCK_STEPS  = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    gray_in,
    input  logic                     in_valid,
    output logic [DATA_WIDTH-1:0]    bin_out,
    output logic                     bin_valid,
    output logic                     step_err,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int CW = (RELOCK_STEPS > 1) ? $clog2(RELOCK_STEPS) : 1;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [CW-1:0]            good_cnt, good_cnt_next;
    logic [ERR_CNT_WIDTH-1:0] err_next;
    logic [DATA_WIDTH-1:0]    bin_conv, bin_next, delta;
    logic                     good_step, valid_next, err_pulse_next;

    // Each binary bit is the parity of the Gray bits at and above it.
    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // bin_out doubles as the previous-sample register for the step check.
    assign bin_conv  = gray2bin(gray_in);
    assign delta     = bin_conv - bin_out;
    assign good_step = (delta == DATA_WIDTH'(1)) ||
                       ((ALLOW_HOLD != 0) && (delta == '0));

    always_comb begin
        state_next     = state;
        good_cnt_next  = good_cnt;
        err_next       = err_count;
        bin_next       = bin_out;
        valid_next     = 1'b0;
        err_pulse_next = 1'b0;
        if (in_valid) begin
            bin_next   = bin_conv;
            valid_next = 1'b1;
            case (state)
                ACQUIRE: state_next = TRACK;
                TRACK: begin
                    if (!good_step) begin
                        err_pulse_next = 1'b1;
                        good_cnt_next  = '0;
                        state_next     = FAULT;
                    end
                end
                FAULT: begin
                    if (good_step) begin
                        if (good_cnt == CW'(RELOCK_STEPS - 1)) begin
                            good_cnt_next = '0;
                            state_next    = TRACK;
                        end else begin
                            good_cnt_next = good_cnt + CW'(1);
                        end
                    end else begin
                        err_pulse_next = 1'b1;
                        good_cnt_next  = '0;
                    end
                end
                default: state_next = ACQUIRE;
            endcase
            if (err_pulse_next && (err_count != '1)) begin
                err_next = err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACQUIRE;
            good_cnt  <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            good_cnt  <= good_cnt_next;
            bin_out   <= bin_next;
            bin_valid <= valid_next;
            step_err  <= err_pulse_next;
            locked    <= (state_next == TRACK);
            err_count <= err_next;
        end
    end

endmodule
